// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------------------------------------------------------------------------
// Shares one word-wide, byte-addressed memory port between the instruction
// fetch requester (I) and the load/store requester (D).
//
// Arbitration is per cycle:
//   - D wins when both requesters are valid.
//   - I wins when D has already been granted MAX_DSTREAK times in a row while
//     I was waiting.
// Every granted address is checked against the memory window and for word
// alignment. A faulting access never reaches the memory pins. Each grant
// produces exactly one registered response to its owner one cycle later.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   i_req_*  / i_rsp_*  fetch request handshake and response
//   d_req_*  / d_rsp_*  load/store request handshake and response
//   mem_*_o             drive for the memory instance (combinational)
//   mem_data_i          combinational read data from the memory instance
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned       AWIDTH      = 32,
  parameter int unsigned       DWIDTH      = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR   = AWIDTH'(32'h0100_0000),
  parameter logic [AWIDTH-1:0] MEM_BYTES   = AWIDTH'(32'h0010_0000),
  parameter int unsigned       MAX_DSTREAK = 3
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req_valid_i,
  output logic              i_req_ready_o,
  input  logic [AWIDTH-1:0] i_addr_i,
  output logic              i_rsp_valid_o,
  output logic [DWIDTH-1:0] i_rsp_data_o,
  output logic              i_rsp_err_o,

  input  logic              d_req_valid_i,
  output logic              d_req_ready_o,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  input  logic              d_we_i,
  output logic              d_rsp_valid_o,
  output logic [DWIDTH-1:0] d_rsp_data_o,
  output logic              d_rsp_err_o,

  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_e;

  // Window bounds are one bit wider than an address, so BASE_ADDR+MEM_BYTES
  // can never wrap around to a small value.
  localparam logic [AWIDTH:0] LO_ADDR   = {1'b0, BASE_ADDR};
  localparam logic [AWIDTH:0] LAST_WORD = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES}
                                          - (AWIDTH+1)'(4);
  localparam logic [3:0]      MAX_S     = 4'(MAX_DSTREAK);

  logic [3:0]        streak_q, streak_d;
  gnt_e              gnt;
  logic [AWIDTH-1:0] gnt_addr;
  logic              fault;
  logic              access_ok;

  logic              i_rsp_valid_q, i_rsp_valid_d;
  logic              i_rsp_err_q,   i_rsp_err_d;
  logic [DWIDTH-1:0] i_rsp_data_q,  i_rsp_data_d;
  logic              d_rsp_valid_q, d_rsp_valid_d;
  logic              d_rsp_err_q,   d_rsp_err_d;
  logic [DWIDTH-1:0] d_rsp_data_q,  d_rsp_data_d;

  // ---------------------------------------------------------------------------
  // Grant selection and address check
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default at the top, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = GNT_NONE;
    if (d_req_valid_i && !(i_req_valid_i && (streak_q == MAX_S))) begin
      gnt = GNT_D;
    end else if (i_req_valid_i) begin
      gnt = GNT_I;
    end
  end

  assign i_req_ready_o = (gnt == GNT_I);
  assign d_req_ready_o = (gnt == GNT_D);

  assign gnt_addr  = (gnt == GNT_D) ? d_addr_i : i_addr_i;
  assign fault     = ({1'b0, gnt_addr} < LO_ADDR)
                  || ({1'b0, gnt_addr} > LAST_WORD)
                  || (gnt_addr[1:0] != 2'b00);
  assign access_ok = (gnt != GNT_NONE) && !fault;

  // ---------------------------------------------------------------------------
  // Memory drive: idle (all zero) unless a clean grant is present
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    if (access_ok) begin
      mem_addr_o = gnt_addr;
      if ((gnt == GNT_D) && d_we_i) begin
        mem_write_en_o = 1'b1;
        mem_data_o     = d_wdata_i;
      end else begin
        mem_read_en_o  = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Streak counter and next-state responses
  // ---------------------------------------------------------------------------
  always_comb begin
    streak_d = '0;
    // Counts only D grants that made a waiting I lose; saturates at MAX_S.
    if ((gnt == GNT_D) && i_req_valid_i) begin
      streak_d = (streak_q == MAX_S) ? streak_q : streak_q + 4'd1;
    end

    i_rsp_valid_d = (gnt == GNT_I);
    i_rsp_err_d   = (gnt == GNT_I) && fault;
    i_rsp_data_d  = ((gnt == GNT_I) && !fault) ? mem_data_i : '0;

    d_rsp_valid_d = (gnt == GNT_D);
    d_rsp_err_d   = (gnt == GNT_D) && fault;
    // Stores return zero data; only a clean load captures the memory word.
    d_rsp_data_d  = ((gnt == GNT_D) && !fault && !d_we_i) ? mem_data_i : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q      <= '0;
      i_rsp_valid_q <= 1'b0;
      i_rsp_err_q   <= 1'b0;
      i_rsp_data_q  <= '0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_err_q   <= 1'b0;
      d_rsp_data_q  <= '0;
    end else begin
      streak_q      <= streak_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      i_rsp_err_q   <= i_rsp_err_d;
      i_rsp_data_q  <= i_rsp_data_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_err_q   <= d_rsp_err_d;
      d_rsp_data_q  <= d_rsp_data_d;
    end
  end

  assign i_rsp_valid_o = i_rsp_valid_q;
  assign i_rsp_err_o   = i_rsp_err_q;
  assign i_rsp_data_o  = i_rsp_data_q;
  assign d_rsp_valid_o = d_rsp_valid_q;
  assign d_rsp_err_o   = d_rsp_err_q;
  assign d_rsp_data_o  = d_rsp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural word memory behind it.
// Inputs change on the falling edge; combinational outputs are sampled 1 ns
// later and registered responses are sampled on the following falling edge.
module tb_mem_arbiter;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam logic [31:0] JUNK  = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
  logic [31:0] i_addr, i_rsp_data;
  logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_err;
  logic [31:0] d_addr, d_wdata, d_rsp_data;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read_en, mem_write_en;

  int n_total = 0;
  int n_bad   = 0;

  mem_arbiter #(
    .AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE),
    .MEM_BYTES(32'h0010_0000), .MAX_DSTREAK(3)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid_i(i_req_valid), .i_req_ready_o(i_req_ready), .i_addr_i(i_addr),
    .i_rsp_valid_o(i_rsp_valid), .i_rsp_data_o(i_rsp_data), .i_rsp_err_o(i_rsp_err),
    .d_req_valid_i(d_req_valid), .d_req_ready_o(d_req_ready), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_we_i(d_we),
    .d_rsp_valid_o(d_rsp_valid), .d_rsp_data_o(d_rsp_data), .d_rsp_err_o(d_rsp_err),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_read_en_o(mem_read_en), .mem_write_en_o(mem_write_en),
    .mem_data_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1 MiB memory; reads are combinational and return a junk
  // pattern when read_en is low so leaked data is visible.
  logic [31:0] mem [0:262143];
  logic [31:0] mem_off;
  assign mem_off   = mem_addr - BASE;
  assign mem_rdata = mem_read_en ? mem[mem_off[19:2]] : JUNK;

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_off[19:2]] <= mem_wdata;
  end

  initial begin
    mem[0]      <= 32'h1111_0000;
    mem[1]      <= 32'h2222_0004;
    mem[2]      <= 32'h3333_0008;
    mem[4]      <= 32'h0000_0000;
    mem[262143] <= 32'hCAFE_F00D;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia,
                       input logic dv, input logic [31:0] da,
                       input logic [31:0] wd, input logic we);
    i_req_valid = iv;
    i_addr      = ia;
    d_req_valid = dv;
    d_addr      = da;
    d_wdata     = wd;
    d_we        = we;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] i_words [2];
  logic [31:0] bad_addrs [3];
  logic        exp_d;

  initial begin
    i_words[0]   = 32'h1111_0000;
    i_words[1]   = 32'h2222_0004;
    bad_addrs[0] = 32'h00FF_FFFC;
    bad_addrs[1] = 32'h0110_0000;
    bad_addrs[2] = 32'h0100_0002;

    // ---- reset state ----
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    #1;
    check("rst_i_rsp_valid", 32'(i_rsp_valid), 32'd0);
    check("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    check("rst_i_rsp_data",  i_rsp_data, 32'd0);
    check("rst_d_rsp_err",   32'(d_rsp_err), 32'd0);
    check("rst_readys",      {30'd0, i_req_ready, d_req_ready}, 32'd0);
    check("rst_mem_en",      {30'd0, mem_read_en, mem_write_en}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // ---- 1: back-to-back fetches ----
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, BASE + 32'(4*k), 1'b0, '0, '0, 1'b0);
      #1;
      check("f_ready",  32'(i_req_ready), 32'd1);
      check("f_mem_en", {30'd0, mem_read_en, mem_write_en}, 32'b10);
      check("f_addr",   mem_addr, BASE + 32'(4*k));
      tick();
      check("f_rsp_valid", 32'(i_rsp_valid), 32'd1);
      check("f_rsp_data",  i_rsp_data, i_words[k]);
      check("f_rsp_err",   32'(i_rsp_err), 32'd0);
      check("f_d_quiet",   32'(d_rsp_valid), 32'd0);
    end

    // ---- 2: store then load the same word ----
    drive(1'b0, '0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 1'b1);
    #1;
    check("st_mem_en", {30'd0, mem_read_en, mem_write_en}, 32'b01);
    check("st_wdata",  mem_wdata, 32'hDEAD_BEEF);
    check("st_addr",   mem_addr, BASE + 32'h10);
    tick();
    check("st_rsp_valid", 32'(d_rsp_valid), 32'd1);
    check("st_rsp_data",  d_rsp_data, 32'd0);
    check("st_rsp_err",   32'(d_rsp_err), 32'd0);
    drive(1'b0, '0, 1'b1, BASE + 32'h10, '0, 1'b0);
    #1;
    check("ld_mem_en", {30'd0, mem_read_en, mem_write_en}, 32'b10);
    tick();
    check("ld_rsp_valid", 32'(d_rsp_valid), 32'd1);
    check("ld_rsp_data",  d_rsp_data, 32'hDEAD_BEEF);
    check("ld_rsp_err",   32'(d_rsp_err), 32'd0);

    // ---- 3: contention, expect D,D,D,I repeating ----
    drive(1'b1, BASE, 1'b1, BASE + 32'h8, '0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      exp_d = ((c % 4) != 3);
      #1;
      check("arb_d_ready", 32'(d_req_ready), 32'(exp_d));
      check("arb_i_ready", 32'(i_req_ready), 32'(!exp_d));
      tick();
      if (exp_d) check("arb_d_rsp", d_rsp_data, 32'h3333_0008);
      else       check("arb_i_rsp", i_rsp_data, 32'h1111_0000);
    end

    // ---- 4: faulting accesses ----
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b1, bad_addrs[k], '0, 1'b0);
      #1;
      check("flt_ready",  32'(d_req_ready), 32'd1);
      check("flt_mem_en", {30'd0, mem_read_en, mem_write_en}, 32'd0);
      check("flt_addr",   mem_addr, 32'd0);
      tick();
      check("flt_rsp_valid", 32'(d_rsp_valid), 32'd1);
      check("flt_rsp_err",   32'(d_rsp_err), 32'd1);
      check("flt_rsp_data",  d_rsp_data, 32'd0);
    end
    drive(1'b0, '0, 1'b1, 32'h0110_0000, 32'h1234_5678, 1'b1);
    #1;
    check("fst_mem_en", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    check("fst_wdata",  mem_wdata, 32'd0);
    tick();
    check("fst_rsp_err",  32'(d_rsp_err), 32'd1);
    check("fst_rsp_data", d_rsp_data, 32'd0);
    // The faulting store must not have landed anywhere (offset 0x100000 would alias word 0).
    drive(1'b0, '0, 1'b1, BASE, '0, 1'b0);
    tick();
    check("fst_word0_kept", d_rsp_data, 32'h1111_0000);

    // ---- 5: last word of the window ----
    drive(1'b0, '0, 1'b1, 32'h010F_FFFC, '0, 1'b0);
    #1;
    check("last_mem_en", {30'd0, mem_read_en, mem_write_en}, 32'b10);
    tick();
    check("last_rsp_err",  32'(d_rsp_err), 32'd0);
    check("last_rsp_data", d_rsp_data, 32'hCAFE_F00D);

    // ---- 6: async reset mid-stream ----
    drive(1'b1, BASE, 1'b1, BASE + 32'h8, '0, 1'b0);
    tick();                       // D grant, streak 1
    @(posedge clk);               // D grant, streak 2
    #2;
    check("rst_pre_valid", 32'(d_rsp_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_async_valid", 32'(d_rsp_valid), 32'd0);
    check("rst_async_data",  d_rsp_data, 32'd0);
    check("rst_async_ivalid", 32'(i_rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    // A cleared streak gives a full D,D,D,I run again.
    for (int c = 0; c < 4; c++) begin
      exp_d = (c != 3);
      #1;
      check("post_rst_d_ready", 32'(d_req_ready), 32'(exp_d));
      tick();
    end

    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-addressable instruction/data memory port between the fetch requester (I) and the load/store requester (D).
- Sits between fetch, the future memory stage, and the memory instance; it drives the memory's addr/data/read_en/write_en pins.
- Grants at most one access per cycle with fixed data priority plus an anti-starvation counter.
- Range-checks and alignment-checks every access, and returns registered responses one cycle after the grant.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width (word access only)
BASE_ADDR, 32'h0100_0000, first valid memory byte address
MEM_BYTES, 32'h0010_0000, memory size in bytes; valid range is [BASE_ADDR, BASE_ADDR+MEM_BYTES)
MAX_DSTREAK, 3, max consecutive D grants while I is waiting (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
i_req_valid_i  in  1  fetch request valid
i_req_ready_o  out  1  fetch request accepted this cycle
i_addr_i  in  AWIDTH  fetch byte address
i_rsp_valid_o  out  1  fetch response valid (1-cycle pulse)
i_rsp_data_o  out  DWIDTH  fetched instruction
i_rsp_err_o  out  1  fetch access fault
d_req_valid_i  in  1  data request valid
d_req_ready_o  out  1  data request accepted this cycle
d_addr_i  in  AWIDTH  data byte address
d_wdata_i  in  DWIDTH  store data
d_we_i  in  1  1=store, 0=load
d_rsp_valid_o  out  1  data response valid (1-cycle pulse)
d_rsp_data_o  out  DWIDTH  load data (0 for stores)
d_rsp_err_o  out  1  data access fault
mem_addr_o  out  AWIDTH  memory address
mem_data_o  out  DWIDTH  memory write data
mem_read_en_o  out  1  memory read enable
mem_write_en_o  out  1  memory write enable
mem_data_i  in  DWIDTH  memory read data (combinational)

Behaviour:
- Reset (rst=0, async):
  - all *_rsp_valid_o, *_rsp_err_o = 0; *_rsp_data_o = 0.
  - streak counter = 0.
  - Memory and ready outputs follow the combinational rules below, which evaluate to idle when no valid is asserted.
  - Responses in flight at reset assertion are dropped, not replayed.
- Handshake:
  - A requester asserts valid and holds addr/wdata/we stable until ready=1. Transfer occurs when valid && ready in the same cycle.
  - Ready is combinational from valid and the streak counter; it never depends on mem_data_i.
- Arbitration, per cycle:
  - Only one valid: that requester is granted.
  - Both valid: D is granted unless streak == MAX_DSTREAK, in which case I is granted.
- Streak counter, updated on the clock edge:
  - D granted while I valid: +1, saturating at MAX_DSTREAK.
  - I granted, or I not valid: reset to 0.
- Fault check on the granted address:
  - fault = (addr < BASE_ADDR) || (addr > BASE_ADDR+MEM_BYTES-4) || (addr[1:0] != 0).
  - Arithmetic is AWIDTH+1 bits so that no wrap-around occurs.
- Memory drive, combinational, in the grant cycle:
  - Granted and no fault: mem_addr_o = granted addr. Load/fetch sets read_en=1, write_en=0. Store sets read_en=0, write_en=1, mem_data_o = d_wdata_i.
  - Faulting grant or no grant: read_en=0, write_en=0, mem_addr_o=0, mem_data_o=0.
  - A faulting store never writes.
- Response, registered, latency 1:
  - On the edge after grant, the owner's rsp_valid=1 for exactly one cycle.
  - rsp_data = mem_data_i sampled at that edge for a successful read; otherwise 0.
  - rsp_err = fault.
  - The non-granted side's rsp_valid = 0.
  - Responses have no backpressure; requesters must sink them.
- Throughput: back-to-back grants every cycle are allowed. A new grant can coincide with the previous response cycle.
- Store response: data 0, err 0 on success.
- No combinational path from *_req_valid_i to *_rsp_*.

Test Plan:
1. Reset, then I-only requests at 0x0100_0000, 0x0100_0004, held every cycle -> i_req_ready_o=1 each cycle; i_rsp_valid_o one cycle later with the words preloaded at those addresses; err=0; mem_read_en_o=1, mem_write_en_o=0.
2. D store 0xDEADBEEF to 0x0100_0010, then D load from 0x0100_0010 next cycle -> cycle 0: write_en=1, read_en=0, mem_data_o=0xDEADBEEF; load response data=0xDEADBEEF, err=0; store response data 0.
3. I and D both valid continuously, MAX_DSTREAK=3 -> grant sequence D,D,D,I,D,D,D,I...; I never waits more than 3 cycles.
4. D load at 0x00FF_FFFC, 0x0110_0000 and 0x0100_0002 -> no memory enable asserted; d_rsp_err_o=1, data 0, one cycle later. Store at 0x0110_0000 -> memory contents unchanged.
5. Boundary load at 0x010F_FFFC (last word) -> err=0 with correct data.
6. Assert rst low mid-stream, with a grant issued the previous cycle -> rsp_valid drops to 0 immediately (async); streak 0 after release. The first post-reset grant of a contended request goes to D.
